stack_alu_sequencer: RTL and testbench
======================================

# stack_alu_sequencer

Expression sequencer driving the stack-based ALU from a token stream. Accepts postfix (RPN) tokens over a valid/ready handshake and translates each into one ALU opcode cycle. On end-of-expression it pops the final value and returns it with a sticky overflow flag and an error flag. It sits upstream of STACK_BASED_ALU and is the producer of that block's opcode/input_data stream and the consumer of its output_data/overflow.

## Interface
- N, 8, data width; must equal the ALU instance's width
- DEPTH, 16, ALU stack capacity in entries; used for depth tracking
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tok_valid  in  1  token present
- tok_ready  out  1  sequencer accepts token this cycle
- tok_kind  in  2  00 operand, 01 add, 10 multiply, 11 end-of-expression
- tok_data  in  N  signed operand; ignored for non-operand kinds
- alu_opcode  out  3  100 add, 101 mul, 110 push, 111 pop, 000 nop
- alu_input_data  out  N  operand for push
- alu_output_data  in  N  ALU result, valid the cycle after the ALU samples an op
- alu_overflow  in  1  ALU overflow for the last add/mul
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  N  final expression value
- res_overflow  out  1  any add/mul in the expression overflowed
- res_error  out  1  malformed expression; res_data is 0

## Operation
- Internal depth counter, 0..DEPTH, mirrors ALU stack occupancy; sticky ovf and err bits cleared when a result is consumed.
- States: ACCEPT, ISSUE, SAMPLE, DRAIN, RESULT.
- ACCEPT: tok_ready=1. On handshake:
  - operand: alu_opcode<=110, alu_input_data<=tok_data, depth+1; remain in ACCEPT.
  - add/mul: alu_opcode<=100/101, depth-1; go to ISSUE.
  - end: if depth==1, alu_opcode<=111, depth<=0, go to ISSUE; otherwise set err and go to DRAIN.
- ISSUE: alu_opcode<=000; ALU executes the op on this cycle's closing edge; go to SAMPLE.
- SAMPLE: after add/mul, ovf|=alu_overflow and return to ACCEPT. After pop, res_data<=alu_output_data and go to RESULT.
- DRAIN: issue 111 each cycle while depth>0, decrementing. At depth==0, res_data<=0 and go to RESULT.
- RESULT: res_valid=1, holding res_data/res_overflow/res_error stable; on res_ready go to ACCEPT and clear ovf/err.
- Arithmetic is performed by the ALU only; the sequencer never modifies data. Results wrap to N bits as the ALU defines.

## Timing
- Reset values: alu_opcode=000, alu_input_data=0, tok_ready=0, res_valid=0, res_data=0, res_overflow=0, res_error=0, depth=0. State is ACCEPT; tok_ready rises the first cycle after rst deasserts.
- alu_opcode is registered and each non-nop code is held exactly one cycle, except back-to-back operand pushes, which produce consecutive 110 cycles.
- Operator latency: accept edge, then 2 cycles (ISSUE, SAMPLE) before tok_ready returns.
- End-to-result latency: 3 edges from accepting end to res_valid=1.
- tok_ready=0 in ISSUE, SAMPLE, DRAIN, RESULT; tokens presented there are not consumed.
- res_valid with res_ready high on the same cycle: result consumed at that edge, ACCEPT next cycle.
- rst mid-expression: immediate return to reset values. The ALU shares rst, so both stacks clear together.

## Configuration
- STACK_SEQ_DEPTH_CHECK_EN defined:
  - Operand at depth==DEPTH and add/mul at depth<2 set err, issue no opcode, and go to DRAIN.
- Undefined:
  - Tokens are forwarded unchecked. The depth counter saturates at 0 and DEPTH.
  - Only the end-of-expression depth!=1 check produces res_error.

## Test plan
- N=8: tokens 7, 4, add, end -> opcodes 110,110,100,000,000,111; res_data=11, res_overflow=0, res_error=0.
- N=8: 64, 3, mul, end -> res_overflow=1, res_data equals ALU's wrapped product; next expression 2, 3, add, end -> res_overflow=0, res_data=5.
- N=8: 5, 6, end -> res_error=1, res_data=0, exactly two 111 drain cycles, depth returns to 0.
- With STACK_SEQ_DEPTH_CHECK_EN: 5, add -> res_error=1, no 100 issued, one drain pop. Without it: 100 is issued.
- res_ready held low 10 cycles -> res_valid and res_* held stable, tok_ready=0 throughout.
- rst asserted during ISSUE of a mul -> all outputs return to reset values asynchronously. Next expression 1, 1, add, end -> res_data=2.

Source files
------------

// File: rtl/stack_alu_sequencer_if.sv
// Token / ALU / result bundle between the expression sequencer and its neighbours.
// slave: the sequencer side. master: the environment (token source, ALU, result sink).
interface stack_alu_sequencer_if #(
    parameter int N = 8
);
    logic         tok_valid;
    logic         tok_ready;
    logic [1:0]   tok_kind;
    logic [N-1:0] tok_data;

    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_input_data;
    logic [N-1:0] alu_output_data;
    logic         alu_overflow;

    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_overflow;
    logic         res_error;

    modport slave (
        input  tok_valid, tok_kind, tok_data,
        output tok_ready,
        output alu_opcode, alu_input_data,
        input  alu_output_data, alu_overflow,
        output res_valid, res_data, res_overflow, res_error,
        input  res_ready
    );

    modport master (
        output tok_valid, tok_kind, tok_data,
        input  tok_ready,
        input  alu_opcode, alu_input_data,
        output alu_output_data, alu_overflow,
        input  res_valid, res_data, res_overflow, res_error,
        output res_ready
    );
endinterface

// File: rtl/stack_alu_sequencer.sv
// RPN token stream -> stack ALU opcode sequencer.
// Each accepted token becomes one registered ALU opcode cycle; end-of-expression
// pops the final value and presents it with sticky overflow / error flags.
// Optional build macro STACK_SEQ_DEPTH_CHECK_EN: reject pushes into a full stack
// and operators with fewer than two operands (error + drain, no opcode issued).
module stack_alu_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_alu_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);
    localparam logic [DW-1:0] D0   = '0;
    localparam logic [DW-1:0] D1   = DW'(1);
    localparam logic [DW-1:0] D2   = DW'(2);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_ADD  = 2'b01;
    localparam logic [1:0] K_MUL  = 2'b10;
    localparam logic [1:0] K_END  = 2'b11;

    typedef enum logic [2:0] {ACCEPT, ISSUE, SAMPLE, DRAIN, RESULT} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] depth, depth_nx;
    logic          ovf, ovf_nx;
    logic          err, err_nx;
    logic          is_pop, is_pop_nx;   // ISSUE/SAMPLE belong to the final pop
    logic          rdy, rdy_nx;
    logic [2:0]    opcode, opcode_nx;
    logic [N-1:0]  in_data, in_data_nx;
    logic [N-1:0]  res_q, res_nx;

    logic hs;
    logic push_bad, arith_bad;

    assign hs = bus.tok_valid & rdy & (state == ACCEPT);

`ifdef STACK_SEQ_DEPTH_CHECK_EN
    assign push_bad  = (depth == DMAX);
    assign arith_bad = (depth < D2);
`else
    assign push_bad  = 1'b0;
    assign arith_bad = 1'b0;
`endif

    // State and all output-facing registers; everything clears on async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCEPT;
            depth   <= D0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            is_pop  <= 1'b0;
            rdy     <= 1'b0;
            opcode  <= OP_NOP;
            in_data <= '0;
            res_q   <= '0;
        end else begin
            state   <= state_nx;
            depth   <= depth_nx;
            ovf     <= ovf_nx;
            err     <= err_nx;
            is_pop  <= is_pop_nx;
            rdy     <= rdy_nx;
            opcode  <= opcode_nx;
            in_data <= in_data_nx;
            res_q   <= res_nx;
        end
    end

    // Next-state: operators and a well-formed end go through ISSUE/SAMPLE, faults drain.
    always_comb begin
        state_nx = state;
        case (state)
            ACCEPT: begin
                if (hs) begin
                    case (bus.tok_kind)
                        K_OPND:       if (push_bad) state_nx = DRAIN;
                        K_ADD, K_MUL: state_nx = arith_bad ? DRAIN : ISSUE;
                        default:      state_nx = (depth == D1) ? ISSUE : DRAIN;
                    endcase
                end
            end
            ISSUE:   state_nx = SAMPLE;
            SAMPLE:  state_nx = is_pop ? RESULT : ACCEPT;
            DRAIN:   if (depth == D0) state_nx = RESULT;
            RESULT:  if (bus.res_ready) state_nx = ACCEPT;
            default: state_nx = ACCEPT;
        endcase
    end

    // Next register values: opcode defaults to nop so every non-nop lasts one cycle.
    always_comb begin
        opcode_nx  = OP_NOP;
        in_data_nx = in_data;
        depth_nx   = depth;
        ovf_nx     = ovf;
        err_nx     = err;
        is_pop_nx  = is_pop;
        res_nx     = res_q;
        case (state)
            ACCEPT: begin
                if (hs) begin
                    case (bus.tok_kind)
                        K_OPND: begin
                            if (push_bad) begin
                                err_nx = 1'b1;
                            end else begin
                                opcode_nx  = OP_PUSH;
                                in_data_nx = bus.tok_data;
                                if (depth != DMAX) depth_nx = depth + D1;
                            end
                        end
                        K_ADD, K_MUL: begin
                            if (arith_bad) begin
                                err_nx = 1'b1;
                            end else begin
                                opcode_nx = (bus.tok_kind == K_ADD) ? OP_ADD : OP_MUL;
                                is_pop_nx = 1'b0;
                                if (depth != D0) depth_nx = depth - D1;
                            end
                        end
                        K_END: begin
                            if (depth == D1) begin
                                opcode_nx = OP_POP;
                                depth_nx  = D0;
                                is_pop_nx = 1'b1;
                            end else begin
                                err_nx = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SAMPLE: begin
                // ALU result/flag are valid the cycle after it sampled the op
                if (is_pop) res_nx = bus.alu_output_data;
                else        ovf_nx = ovf | bus.alu_overflow;
            end
            DRAIN: begin
                if (depth != D0) begin
                    opcode_nx = OP_POP;
                    depth_nx  = depth - D1;
                end else begin
                    res_nx = '0;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    ovf_nx = 1'b0;
                    err_nx = 1'b0;
                end
            end
            default: ;
        endcase
        rdy_nx = (state_nx == ACCEPT);
    end

    // Port drive: all from registers or decoded state, no input-to-output paths.
    always_comb begin
        bus.tok_ready      = rdy;
        bus.alu_opcode     = opcode;
        bus.alu_input_data = in_data;
        bus.res_valid      = (state == RESULT);
        bus.res_data       = res_q;
        bus.res_overflow   = ovf;
        bus.res_error      = err;
    end
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a behavioural stack ALU attached.
module tb_stack_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_alu_sequencer_if #(.N(8)) b();
    stack_alu_sequencer #(.N(8), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(b.slave));

    // ---------------- behavioural stack ALU ----------------
    int          asp;
    logic [7:0]  astk [16];
    logic [7:0]  aout;
    logic        aovf;
    logic [15:0] sa, sb, wide;
    logic [7:0]  ares;

    assign sa   = (asp >= 1) ? {{8{astk[4'(asp-1)][7]}}, astk[4'(asp-1)]} : 16'h0;
    assign sb   = (asp >= 2) ? {{8{astk[4'(asp-2)][7]}}, astk[4'(asp-2)]} : 16'h0;
    assign wide = (b.alu_opcode == 3'b101) ? 16'($signed(sa) * $signed(sb)) : (sa + sb);
    assign ares = wide[7:0];
    assign b.alu_output_data = aout;
    assign b.alu_overflow    = aovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            asp  <= 0;
            aout <= 8'h0;
            aovf <= 1'b0;
        end else begin
            case (b.alu_opcode)
                3'b110: if (asp < 16) begin astk[4'(asp)] <= b.alu_input_data; asp <= asp + 1; end
                3'b111: begin aout <= sa[7:0]; if (asp > 0) asp <= asp - 1; end
                3'b100, 3'b101: begin
                    aout <= ares;
                    aovf <= (wide != {{8{ares[7]}}, ares});
                    astk[4'((asp >= 2) ? asp - 2 : 0)] <= ares;
                    asp  <= (asp >= 2) ? asp - 1 : 1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- opcode trace ----------------
    logic [2:0] trace [$];
    always @(negedge clk) if (!rst) trace.push_back(b.alu_opcode);

    function automatic int count_op(input logic [2:0] op);
        int c = 0;
        foreach (trace[i]) if (trace[i] == op) c++;
        return c;
    endfunction

    // ---------------- checking ----------------
    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [9:0] TADD = 10'h100;
    localparam logic [9:0] TMUL = 10'h200;
    localparam logic [9:0] TEND = 10'h300;
    function automatic logic [9:0] opd(input logic [7:0] d);
        return {2'b00, d};
    endfunction

    task automatic send_tok(input logic [9:0] t);
        int n = 0;
        @(negedge clk);
        b.tok_valid = 1'b1;
        b.tok_kind  = t[9:8];
        b.tok_data  = t[7:0];
        while (!b.tok_ready && n < 50) begin @(negedge clk); n++; end
        if (!b.tok_ready) begin
            ncmp++; nerr++;
            $display("FAIL tok_accept: tok_ready stuck at 0, required 1");
            b.tok_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            b.tok_valid = 1'b0;
        end
    endtask

    task automatic get_res(input string name, input logic [7:0] ed, input logic eo, input logic ee);
        int n = 0;
        @(negedge clk);
        while (!b.res_valid && n < 60) begin @(negedge clk); n++; end
        if (!b.res_valid) begin
            ncmp++; nerr++;
            $display("FAIL %s_timeout: res_valid stuck at 0, required 1", name);
        end else begin
            chk({name, "_data"}, 32'(b.res_data), 32'(ed));
            chk({name, "_ovf"}, 32'(b.res_overflow), 32'(eo));
            chk({name, "_err"}, 32'(b.res_error), 32'(ee));
            b.res_ready = 1'b1;
            @(posedge clk); #1;
            b.res_ready = 1'b0;
            @(negedge clk);
            chk({name, "_ready_after"}, 32'(b.tok_ready), 32'd1);
        end
    endtask

    typedef struct {
        string            name;
        int               n;
        logic [5:0][9:0]  tok;
        logic [7:0]       ed;
        logic             eo;
        logic             ee;
    } vec_t;

    vec_t vt [10];
    int   nv = 0;

    task automatic add_vec(input string nm, input int n,
                           input logic [9:0] t0, t1, t2, t3, t4, t5,
                           input logic [7:0] ed, input logic eo, input logic ee);
        vt[nv].name = nm;  vt[nv].n = n;
        vt[nv].tok[0] = t0; vt[nv].tok[1] = t1; vt[nv].tok[2] = t2;
        vt[nv].tok[3] = t3; vt[nv].tok[4] = t4; vt[nv].tok[5] = t5;
        vt[nv].ed = ed; vt[nv].eo = eo; vt[nv].ee = ee;
        nv++;
    endtask

    initial begin
        int n;
        int first;
        logic [2:0] exp_tr [6];
        b.tok_valid = 1'b0; b.tok_kind = 2'b00; b.tok_data = 8'h0; b.res_ready = 1'b0;

        // vectors: {tokens} -> {res_data, res_overflow, res_error}
        add_vec("mul_ovf", 4, opd(8'd64), opd(8'd3), TMUL, TEND, 0, 0, 8'hC0, 1'b1, 1'b0);
        add_vec("add_clr", 4, opd(8'd2), opd(8'd3), TADD, TEND, 0, 0, 8'h05, 1'b0, 1'b0);
        add_vec("add_ovf", 4, opd(8'd100), opd(8'd50), TADD, TEND, 0, 0, 8'h96, 1'b1, 1'b0);
        add_vec("mul_neg", 4, opd(8'hFD), opd(8'd5), TMUL, TEND, 0, 0, 8'hF1, 1'b0, 1'b0);
        add_vec("nested",  6, opd(8'd2), opd(8'd3), opd(8'd4), TMUL, TADD, TEND, 8'h0E, 1'b0, 1'b0);
        add_vec("mul_min", 4, opd(8'h80), opd(8'hFF), TMUL, TEND, 0, 0, 8'h80, 1'b1, 1'b0);
        add_vec("add_max", 4, opd(8'd127), opd(8'd1), TADD, TEND, 0, 0, 8'h80, 1'b1, 1'b0);
        add_vec("single",  2, opd(8'd9), TEND, 0, 0, 0, 0, 8'h09, 1'b0, 1'b0);
        add_vec("empty",   1, TEND, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);

        // reset values, held while rst is high
        repeat (3) @(negedge clk);
        chk("rst_opcode", 32'(b.alu_opcode), 32'd0);
        chk("rst_indata", 32'(b.alu_input_data), 32'd0);
        chk("rst_tok_ready", 32'(b.tok_ready), 32'd0);
        chk("rst_res_valid", 32'(b.res_valid), 32'd0);
        chk("rst_res_data", 32'(b.res_data), 32'd0);
        chk("rst_res_ovf", 32'(b.res_overflow), 32'd0);
        chk("rst_res_err", 32'(b.res_error), 32'd0);
        rst = 1'b0;
        #1 chk("rel_tok_ready0", 32'(b.tok_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_tok_ready1", 32'(b.tok_ready), 32'd1);

        // 7 4 add end: opcode trace and end-to-result latency
        trace.delete();
        send_tok(opd(8'd7)); send_tok(opd(8'd4)); send_tok(TADD); send_tok(TEND);
        n = 0;
        do begin @(negedge clk); n++; end while (!b.res_valid && n < 20);
        chk("end_latency", 32'(n), 32'd3);
        exp_tr = '{3'b110, 3'b110, 3'b100, 3'b000, 3'b000, 3'b111};
        first = -1;
        foreach (trace[i]) if (first < 0 && trace[i] != 3'b000) first = i;
        if (first < 0 || trace.size() < first + 6) begin
            ncmp++; nerr++;
            $display("FAIL trace_len: size %0d start %0d, required 6 entries", trace.size(), first);
        end else begin
            for (int i = 0; i < 6; i++) chk($sformatf("trace_%0d", i), 32'(trace[first+i]), 32'(exp_tr[i]));
        end
        get_res("basic", 8'd11, 1'b0, 1'b0);

        // table
        for (int i = 0; i < nv; i++) begin
            for (int j = 0; j < vt[i].n; j++) send_tok(vt[i].tok[j]);
            get_res(vt[i].name, vt[i].ed, vt[i].eo, vt[i].ee);
        end

        // 5 6 end: malformed, two drain pops, stack empties
        trace.delete();
        send_tok(opd(8'd5)); send_tok(opd(8'd6)); send_tok(TEND);
        get_res("drain", 8'd0, 1'b0, 1'b1);
        chk("drain_pops", 32'(count_op(3'b111)), 32'd2);
        chk("drain_alu_sp", 32'(asp), 32'd0);

        // result held with res_ready low for 10 cycles, token presented but not taken
        send_tok(opd(8'd9)); send_tok(TEND);
        n = 0;
        do begin @(negedge clk); n++; end while (!b.res_valid && n < 20);
        b.tok_valid = 1'b1; b.tok_kind = 2'b00; b.tok_data = 8'd5;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(b.res_valid), 32'd1);
            chk("hold_data", 32'(b.res_data), 32'd9);
            chk("hold_flags", 32'({b.res_overflow, b.res_error}), 32'd0);
            chk("hold_tok_ready", 32'(b.tok_ready), 32'd0);
            @(negedge clk);
        end
        b.tok_valid = 1'b0;
        b.res_ready = 1'b1;
        @(posedge clk); #1;
        b.res_ready = 1'b0;
        chk("hold_no_push", 32'(asp), 32'd0);

        // operator with one operand
        trace.delete();
        send_tok(opd(8'd5)); send_tok(TADD);
`ifndef STACK_SEQ_DEPTH_CHECK_EN
        send_tok(TEND);
`endif
        get_res("underflow", 8'd0, 1'b0, 1'b1);
`ifdef STACK_SEQ_DEPTH_CHECK_EN
        chk("underflow_add", 32'(count_op(3'b100)), 32'd0);
        chk("underflow_pops", 32'(count_op(3'b111)), 32'd1);
`else
        chk("underflow_add", 32'(count_op(3'b100)), 32'd1);
        chk("underflow_pops", 32'(count_op(3'b111)), 32'd0);
`endif

        // async reset while a mul sits in ISSUE
        send_tok(opd(8'd100)); send_tok(opd(8'd3)); send_tok(TMUL);
        chk("pre_rst_opcode", 32'(b.alu_opcode), 32'd5);
        rst = 1'b1;
        #1;
        chk("arst_opcode", 32'(b.alu_opcode), 32'd0);
        chk("arst_indata", 32'(b.alu_input_data), 32'd0);
        chk("arst_tok_ready", 32'(b.tok_ready), 32'd0);
        chk("arst_res", 32'({b.res_valid, b.res_overflow, b.res_error, b.res_data}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_tok(opd(8'd1)); send_tok(opd(8'd1)); send_tok(TADD); send_tok(TEND);
        get_res("after_rst", 8'd2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
